// File: rtl/br_pkg.sv
// br_pkg: shared branch-resolution types, tag width and helpers.
package br_pkg;
  localparam int BR_MASK_W = 5;
  typedef enum logic [1:0] {
    BR_NONE       = 2'b00,
    BR_PR_CORRECT = 2'b01,
    BR_PR_WRONG   = 2'b10
  } br_state_t;
  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    WRONG_ISSUE = 2'b01,
    RECOVER     = 2'b10
  } recov_state_t;
  function automatic logic [BR_MASK_W-1:0] lowest_bit(input logic [BR_MASK_W-1:0] m);
    return m & (~m + BR_MASK_W'(1));
  endfunction
endpackage

// File: rtl/br_age_sel.sv
// br_age_sel: picks the oldest candidate among N tag/dep pairs; ties with no age relation go to the lowest index.
module br_age_sel #(
  parameter int N = 2,
  parameter int W = 5,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N*W-1:0] tag_i,
  input  logic [N*W-1:0] dep_i,
  input  logic [N-1:0]   cand_i,
  output logic [N-1:0]   gnt_o,
  output logic [IW-1:0]  idx_o
);
  logic [N-1:0] oldest;
  always_comb begin
    oldest = cand_i;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (j != i && cand_i[j] && |(tag_i[j*W +: W] & dep_i[i*W +: W])) oldest[i] = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--)
      if (oldest[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = IW'(i);
      end
  end
endmodule

// File: rtl/br_resolve_sched.sv
// br_resolve_sched: merges BRU resolutions into one issue per cycle, mispredicts first,
// and runs the recovery stall / squash sequence.
module br_resolve_sched
  import br_pkg::*;
#(
  parameter int NUM_BRU   = 2,
  parameter int RECOV_CYC = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_BRU-1:0]             res_valid_i,
  input  logic [NUM_BRU-1:0]             res_wrong_i,
  input  logic [NUM_BRU*BR_MASK_W-1:0]   res_tag_i,
  input  logic [NUM_BRU*BR_MASK_W-1:0]   res_dep_i,
  output logic [1:0]                     br_state_o,
  output logic [BR_MASK_W-1:0]           br_bit_o,
  output logic [BR_MASK_W-1:0]           br_dep_o,
  output logic                           kill_valid_o,
  output logic [BR_MASK_W-1:0]           kill_tag_o,
  output logic                           stall_o
);
  localparam int IW = NUM_BRU > 1 ? $clog2(NUM_BRU) : 1;
  recov_state_t state_q, state_d;
  br_state_t br_state_q, br_state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [BR_MASK_W-1:0] pend_q, pend_d, br_bit_q, br_bit_d, br_dep_q, br_dep_d;
  logic [BR_MASK_W-1:0] kill_tag_q, kill_tag_d;
  logic kill_valid_q, kill_valid_d, stall_q, stall_d;
  logic [BR_MASK_W-1:0][BR_MASK_W-1:0] dep_q, dep_d;
  logic [BR_MASK_W-1:0] tag [NUM_BRU];
  logic [BR_MASK_W-1:0] dep [NUM_BRU];
  logic [NUM_BRU-1:0] live0, wgnt;
  logic [IW-1:0] widx;
  logic wany;
  logic [BR_MASK_W-1:0] wtag, wdep, in_mask, avail, iss, iss_dep, clr;
  always_comb begin
    for (int i = 0; i < NUM_BRU; i++) begin
      tag[i]   = res_tag_i[i*BR_MASK_W +: BR_MASK_W];
      dep[i]   = res_dep_i[i*BR_MASK_W +: BR_MASK_W];
      live0[i] = res_valid_i[i] && !(kill_valid_q && |(dep[i] & kill_tag_q));
    end
  end
  br_age_sel #(.N(NUM_BRU), .W(BR_MASK_W)) u_age_sel (
    .tag_i  (res_tag_i),
    .dep_i  (res_dep_i),
    .cand_i (live0 & res_wrong_i),
    .gnt_o  (wgnt),
    .idx_o  (widx)
  );
  assign wany = |wgnt;
  assign wtag = tag[widx];
  assign wdep = dep[widx];
  // Corrects younger than this cycle's winning mispredict are squashed before enqueue.
  always_comb begin
    dep_d   = dep_q;
    in_mask = '0;
    for (int i = 0; i < NUM_BRU; i++)
      if (live0[i] && !res_wrong_i[i] && !(wany && |(wtag & dep[i]))) begin
        in_mask = in_mask | tag[i];
        for (int t = 0; t < BR_MASK_W; t++) if (tag[i][t]) dep_d[t] = dep[i];
      end
    avail   = pend_q | in_mask;
    iss     = lowest_bit(avail);
    iss_dep = '0;
    for (int t = 0; t < BR_MASK_W; t++) begin
      iss_dep = iss[t] ? dep_d[t] : iss_dep;
      clr[t]  = |(dep_d[t] & wtag);
    end
    pend_d     = wany ? avail & ~clr : avail & ~iss;
    br_state_d = wany ? BR_PR_WRONG : |avail ? BR_PR_CORRECT : BR_NONE;
    br_bit_d   = wany ? wtag : iss;
    br_dep_d   = wany ? wdep : iss_dep;
    state_d    = wany ? WRONG_ISSUE :
                 state_q == WRONG_ISSUE ? RECOVER :
                 state_q == RECOVER && cnt_q == '0 ? IDLE : state_q;
    cnt_d      = state_q == WRONG_ISSUE ? 4'(RECOV_CYC - 1) :
                 state_q == RECOVER && cnt_q != '0 ? cnt_q - 4'd1 : cnt_q;
    kill_valid_d = state_d != IDLE;
    stall_d      = state_d != IDLE;
    kill_tag_d   = wany ? wtag : state_d == IDLE ? '0 : kill_tag_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pend_q       <= '0;
      dep_q        <= '0;
      br_state_q   <= BR_NONE;
      br_bit_q     <= '0;
      br_dep_q     <= '0;
      kill_valid_q <= 1'b0;
      kill_tag_q   <= '0;
      stall_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      dep_q        <= dep_d;
      br_state_q   <= br_state_d;
      br_bit_q     <= br_bit_d;
      br_dep_q     <= br_dep_d;
      kill_valid_q <= kill_valid_d;
      kill_tag_q   <= kill_tag_d;
      stall_q      <= stall_d;
    end
  end
  assign br_state_o   = br_state_q;
  assign br_bit_o     = br_bit_q;
  assign br_dep_o     = br_dep_q;
  assign kill_valid_o = kill_valid_q;
  assign kill_tag_o   = kill_tag_q;
  assign stall_o      = stall_q;
  // Protocol checks: one-hot tags, no tag resolving twice.
  for (genvar i = 0; i < NUM_BRU; i++) begin : g_chk
    assert property (@(posedge clk) disable iff (!rst_n)
      res_valid_i[i] |-> $onehot(res_tag_i[i*BR_MASK_W +: BR_MASK_W]) &&
                         !(|(res_tag_i[i*BR_MASK_W +: BR_MASK_W] & pend_q)));
    for (genvar j = i + 1; j < NUM_BRU; j++) begin : g_pair
      assert property (@(posedge clk) disable iff (!rst_n)
        res_valid_i[i] && res_valid_i[j] |->
          res_tag_i[i*BR_MASK_W +: BR_MASK_W] != res_tag_i[j*BR_MASK_W +: BR_MASK_W]);
    end
  end
endmodule

// File: tb/tb_br_resolve_sched.sv
// tb_br_resolve_sched: directed table-driven checks of issue ordering, squash filtering and recovery timing.
module tb_br_resolve_sched;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] res_valid_i, res_wrong_i;
  logic [9:0] res_tag_i, res_dep_i;
  logic [1:0] br_state_o;
  logic [4:0] br_bit_o, br_dep_o, kill_tag_o;
  logic kill_valid_o, stall_o;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  br_resolve_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .res_valid_i  (res_valid_i),
    .res_wrong_i  (res_wrong_i),
    .res_tag_i    (res_tag_i),
    .res_dep_i    (res_dep_i),
    .br_state_o   (br_state_o),
    .br_bit_o     (br_bit_o),
    .br_dep_o     (br_dep_o),
    .kill_valid_o (kill_valid_o),
    .kill_tag_o   (kill_tag_o),
    .stall_o      (stall_o)
  );
  typedef struct {
    logic [1:0] v, w;
    logic [4:0] t0, d0, t1, d1;
    logic [1:0] st;
    logic [4:0] bt, dp;
    logic       kv;
    logic [4:0] kt;
    logic       sl;
  } vec_t;
  vec_t vec [23];
  task automatic chk(input string nm, input int idx, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %b want %b", nm, idx, act, exp);
    end
  endtask
  task automatic chk_all(input int idx, input logic [1:0] st, input logic [4:0] bt, input logic [4:0] dp,
                         input logic kv, input logic [4:0] kt, input logic sl);
    chk("br_state", idx, {3'b0, br_state_o}, {3'b0, st});
    chk("br_bit", idx, br_bit_o, bt);
    chk("br_dep", idx, br_dep_o, dp);
    chk("kill_valid", idx, {4'b0, kill_valid_o}, {4'b0, kv});
    chk("kill_tag", idx, kill_tag_o, kt);
    chk("stall", idx, {4'b0, stall_o}, {4'b0, sl});
  endtask
  task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic [4:0] t0, input logic [4:0] d0,
                       input logic [4:0] t1, input logic [4:0] d1);
    res_valid_i = v;
    res_wrong_i = w;
    res_tag_i   = {t1, t0};
    res_dep_i   = {d1, d0};
  endtask
  initial begin
    //          v      w      t0        d0        t1        d1        st     bit       dep       kv    kt        stall
    vec[0]  = '{2'b01, 2'b00, 5'b00100, 5'b00011, 5'b00000, 5'b00000, 2'b01, 5'b00100, 5'b00011, 1'b0, 5'b00000, 1'b0};
    vec[1]  = '{2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b00, 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0};
    vec[2]  = '{2'b11, 2'b00, 5'b00001, 5'b00000, 5'b00010, 5'b00001, 2'b01, 5'b00001, 5'b00000, 1'b0, 5'b00000, 1'b0};
    vec[3]  = '{2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b01, 5'b00010, 5'b00001, 1'b0, 5'b00000, 1'b0};
    vec[4]  = '{2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b00, 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0};
    vec[5]  = '{2'b11, 2'b00, 5'b01000, 5'b00111, 5'b00001, 5'b00000, 2'b01, 5'b00001, 5'b00000, 1'b0, 5'b00000, 1'b0};
    vec[6]  = '{2'b10, 2'b10, 5'b00000, 5'b00000, 5'b00010, 5'b00001, 2'b10, 5'b00010, 5'b00001, 1'b1, 5'b00010, 1'b1};
    vec[7]  = '{2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b00, 5'b00000, 5'b00000, 1'b1, 5'b00010, 1'b1};
    vec[8]  = '{2'b01, 2'b00, 5'b00100, 5'b00011, 5'b00000, 5'b00000, 2'b00, 5'b00000, 5'b00000, 1'b1, 5'b00010, 1'b1};
    vec[9]  = '{2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b00, 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0};
    vec[10] = '{2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b00, 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0};
    vec[11] = '{2'b11, 2'b11, 5'b00100, 5'b00011, 5'b00001, 5'b00000, 2'b10, 5'b00001, 5'b00000, 1'b1, 5'b00001, 1'b1};
    vec[12] = '{2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b00, 5'b00000, 5'b00000, 1'b1, 5'b00001, 1'b1};
    vec[13] = '{2'b01, 2'b01, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 2'b10, 5'b00100, 5'b00000, 1'b1, 5'b00100, 1'b1};
    vec[14] = '{2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b00, 5'b00000, 5'b00000, 1'b1, 5'b00100, 1'b1};
    vec[15] = '{2'b01, 2'b01, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 2'b10, 5'b00001, 5'b00000, 1'b1, 5'b00001, 1'b1};
    vec[16] = '{2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b00, 5'b00000, 5'b00000, 1'b1, 5'b00001, 1'b1};
    vec[17] = '{2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b00, 5'b00000, 5'b00000, 1'b1, 5'b00001, 1'b1};
    vec[18] = '{2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b00, 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0};
    vec[19] = '{2'b11, 2'b01, 5'b00010, 5'b00001, 5'b00001, 5'b00000, 2'b10, 5'b00010, 5'b00001, 1'b1, 5'b00010, 1'b1};
    vec[20] = '{2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b01, 5'b00001, 5'b00000, 1'b1, 5'b00010, 1'b1};
    vec[21] = '{2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b00, 5'b00000, 5'b00000, 1'b1, 5'b00010, 1'b1};
    vec[22] = '{2'b00, 2'b00, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 2'b00, 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0};
    rst_n = 1'b0;
    drive(2'b00, 2'b00, 5'b0, 5'b0, 5'b0, 5'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_all(-1, 2'b00, 5'b0, 5'b0, 1'b0, 5'b0, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 23; k++) begin
      drive(vec[k].v, vec[k].w, vec[k].t0, vec[k].d0, vec[k].t1, vec[k].d1);
      @(posedge clk);
      #1;
      chk_all(k, vec[k].st, vec[k].bt, vec[k].dp, vec[k].kv, vec[k].kt, vec[k].sl);
    end
    drive(2'b01, 2'b01, 5'b00100, 5'b00000, 5'b0, 5'b0);
    @(posedge clk);
    #1;
    chk_all(100, 2'b10, 5'b00100, 5'b00000, 1'b1, 5'b00100, 1'b1);
    drive(2'b00, 2'b00, 5'b0, 5'b0, 5'b0, 5'b0);
    @(posedge clk);
    #1;
    chk_all(101, 2'b00, 5'b0, 5'b0, 1'b1, 5'b00100, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_all(102, 2'b00, 5'b0, 5'b0, 1'b0, 5'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all(103, 2'b00, 5'b0, 5'b0, 1'b0, 5'b0, 1'b0);
    drive(2'b10, 2'b00, 5'b0, 5'b0, 5'b10000, 5'b00001);
    @(posedge clk);
    #1;
    chk_all(104, 2'b01, 5'b10000, 5'b00001, 1'b0, 5'b0, 1'b0);
    drive(2'b00, 2'b00, 5'b0, 5'b0, 5'b0, 5'b0);
    @(posedge clk);
    #1;
    chk_all(105, 2'b00, 5'b0, 5'b0, 1'b0, 5'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/br_resolve_sched.md
Name: br_resolve_sched

Overview:
- Scheduler between the branch execution units (BRUs) and the branch mask controller / branch stack.
- Accepts up to NUM_BRU branch resolutions per cycle and issues at most one resolution per cycle to the mask controller.
- Mispredicts take priority, and the oldest mispredict wins. Correct resolutions are buffered in a pending set and drained one per cycle.
- Runs a recovery FSM that stalls dispatch and drives the squash tag while the branch stack restores state.

Parameters:
- BR_MASK_W, 5, number of branch tags (checkpoint slots); tags are one-hot.
- NUM_BRU, 2, number of resolution sources.
- RECOV_CYC, 2, stall cycles after a WRONG issue (range 1..15).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- res_valid_i  in  NUM_BRU  resolution valid, per BRU.
- res_wrong_i  in  NUM_BRU  1 = mispredicted, 0 = correct.
- res_tag_i  in  NUM_BRU*BR_MASK_W  one-hot tag of the resolving branch.
- res_dep_i  in  NUM_BRU*BR_MASK_W  mask of older in-flight branches captured at dispatch; excludes the branch's own tag.
- br_state_o  out  2  NONE / CORRECT / WRONG to the mask controller.
- br_bit_o  out  BR_MASK_W  one-hot tag being resolved; 0 when NONE.
- br_dep_o  out  BR_MASK_W  dep mask of the issued branch; mask controller restore value on WRONG.
- kill_valid_o  out  1  squash in progress.
- kill_tag_o  out  BR_MASK_W  entries whose mask contains this bit are squashed (RS/ROB/FUs).
- stall_o  out  1  dispatch stall.

Behaviour:
- Reset (rst_n=0 at posedge):
  - FSM goes to IDLE, pend_q=0, all dep_q=0.
  - Outputs: br_state_o=NONE, br_bit_o=0, br_dep_o=0, kill_valid_o=0, kill_tag_o=0, stall_o=0.
  - Reset mid-recovery aborts the recovery immediately.
- All outputs are registered.
- Input filter:
  - An input is *live* if res_valid_i is set and it is not killed.
  - It is killed when kill_valid_q=1 and res_dep_i contains kill_tag_q.
  - It is also killed when it is younger than the mispredict selected in the same cycle.
- Older-than test: A is older than B iff (res_tag_A & res_dep_B) != 0.
- Mispredict selection: the oldest live wrong input wins. If no age relation exists between candidates, the lowest index wins.
- Pending set:
  - pend_q[BR_MASK_W], plus dep_q[t] per tag.
  - A live correct input sets pend_q[tag] and writes dep_q[tag].
- Issue priority each cycle (result visible next cycle):
  1. A selected mispredict gives br_state_o=WRONG, br_bit_o=tag, br_dep_o=dep.
     - Load kill_tag_q=tag and kill_valid_q=1.
     - Clear every pend_q[t] whose dep_q[t] contains tag.
     - Same-cycle correct inputs that are older are still enqueued.
  2. Otherwise, the lowest set bit of (pend_q | live correct inputs this cycle) is issued. br_state_o=CORRECT and br_bit_o is that bit.
     - Bypass rule: a correct input with empty pend_q issues in 1 cycle.
     - The issued bit is cleared from the set.
  3. Otherwise, br_state_o=NONE.
- FSM:
  - IDLE -> WRONG_ISSUE on a mispredict.
  - WRONG_ISSUE (1 cycle, stall_o=1) -> RECOVER, with cnt=RECOV_CYC-1.
  - RECOVER: stall_o=1 and kill_valid_o=1. Decrement cnt; when cnt=0, go to IDLE and clear kill_valid_q.
  - In RECOVER, corrects keep draining one per cycle.
  - A live mispredict in WRONG_ISSUE or RECOVER must be older than kill_tag_q, since younger ones are filtered. It re-enters WRONG_ISSUE, replaces kill_tag_q, and restarts the count.
- The same tag resolving twice, or a non-one-hot tag, is a protocol violation. Behaviour is then undefined; an assertion in simulation is required.

Decomposition:
- Shared package br_pkg:
  - BR_MASK_W.
  - br_state_t enum: BR_NONE=2'b00, BR_PR_CORRECT=2'b01, BR_PR_WRONG=2'b10; must match the mask controller encoding.
  - recov_state_t: IDLE, WRONG_ISSUE, RECOVER.
- One sub-module: br_age_sel. It is combinational, takes NUM_BRU tag/dep pairs plus a candidate mask, and returns the oldest index with a one-hot grant.

Test Plan:
1. Single correct: BRU0 tag=5'b00100, dep=5'b00011. Next cycle: CORRECT, br_bit_o=00100, stall_o=0.
2. Dual correct in the same cycle: tags 00001 and 00010. Response: CORRECT 00001 on cycle t+1, then CORRECT 00010 on t+2, then NONE.
3. Mispredict with younger pending: pend holds tag 01000 (dep 00111). BRU1 wrong tag=00010, dep=00001. Response:
   - WRONG, br_bit_o=00010, br_dep_o=00001, kill_tag_o=00010.
   - pend_q cleared; 01000 is never issued.
   - stall_o high for 1+RECOV_CYC=3 cycles.
4. Same-cycle mispredicts: BRU0 wrong tag=00100 (dep 00011), BRU1 wrong tag=00001 (dep 0). Response: WRONG 00001 only; the BRU0 input is dropped.
5. Late younger resolution: during RECOVER with kill_tag=00010, BRU0 correct tag=00100 with dep=00011 is dropped. Response: no CORRECT and pend unchanged.
6. Older mispredict during RECOVER (kill_tag=00100): BRU0 wrong tag=00001 arrives. Response: WRONG 00001, kill_tag_o becomes 00001, and the stall count restarts. Separately, asserting rst_n=0 mid-RECOVER clears all outputs on the next cycle.
